mult_pipe: RTL and testbench
============================

Name: mult_pipe

Overview:
- Pipelined unsigned 8x8 -> 16-bit shift-and-add multiplier serving the CPU controller's Mult 1..Mult 4 states.
- Sits between the accumulator/memory-data registers (operand source) and the accumulator write-back path (result sink).
- Accepts one operation per cycle with a fixed latency of STAGES cycles, so the four controller Mult states map one-to-one onto the pipe stages.
- Supports stall (freeze) and flush (kill in-flight operations).

Parameters:
- IN_W, 8: operand width. Result width is 2*IN_W.
- STAGES, 4: pipeline depth. Each stage consumes IN_W/STAGES multiplier bits. IN_W must be divisible by STAGES; an elaboration check fails otherwise.
- BUS_W, 16: width of the operand ports. Bits [BUS_W-1:IN_W] are ignored.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair present this cycle
- op_a  in  BUS_W  multiplicand; only op_a[IN_W-1:0] is used
- op_b  in  BUS_W  multiplier; only op_b[IN_W-1:0] is used
- stall  in  1  hold every pipeline register, including valids
- flush  in  1  clear every in-flight valid bit
- out_valid  out  1  prod is the result of an accepted operation
- prod  out  2*IN_W  product
- busy  out  1  OR of all stage valid bits

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low. While rst=0, all stage registers (valid, accumulator, multiplicand, remaining multiplier) are 0, so out_valid=0, prod=0 and busy=0.
- Acceptance: on a rising edge with stall=0 and flush=0, stage 1 captures in_valid, a=op_a[IN_W-1:0], b=op_b[IN_W-1:0], and a partial accumulator. There is no ready signal; the producer honours stall.
- Stage k (k=1..STAGES):
  - Adds (a << j) to the accumulator for each multiplier bit j in slice k that is 1, where j is the absolute bit index.
  - Uses a 2*IN_W-bit adder. There is no overflow, because the product always fits in 2*IN_W bits.
  - Passes a, b and valid to stage k+1.
- Latency: operands presented at edge E give out_valid=1 and prod=a*b after edge E+STAGES-1, i.e. they are visible during cycle STAGES after acceptance (4 cycles at default). prod holds until the next stage-STAGES update.
- Throughput: one operation per cycle. Back-to-back operations emerge on consecutive cycles in order.
- Bubbles: when in_valid=0, a bubble (valid=0) propagates. Data registers still load, but the bench checks prod only when out_valid=1.
- Stall: all registers hold their values; out_valid and prod stay constant for as many cycles as stall is held.
- Flush: all valid bits clear on the edge, and data registers are don't-care. A flush also discards the in_valid presented that cycle. flush has priority over stall.
- Reset mid-operation: every in-flight result is lost and no out_valid is produced.
- Zero operands: a=0 or b=0 gives prod=0 with normal latency.

Decomposition:
- Package mult_pkg holds:
  - IN_W, STAGES and BUS_W defaults
  - the derived constants SLICE_W=IN_W/STAGES and PROD_W=2*IN_W
  - the stage record typedef {valid, a, b, acc}
- One sub-module, mult_stage, parameterised by slice index. Inputs: the previous stage record. Output: the next stage record, built from shift and add. mult_pipe instantiates STAGES copies in a generate loop and owns the registers, stall/flush logic and the output mapping.

Test Plan:
- Basic: rst low for 2 cycles, then op_a=0x0003, op_b=0x0005, in_valid pulsed for 1 cycle -> out_valid high exactly 4 cycles later with prod=0x000F; busy high during cycles 1-4.
- Max and masking: op_a=0xABFF, op_b=0x12FF -> prod=0xFE01 (255*255=65025); upper bytes have no effect.
- Streaming: 6 consecutive pairs (1x1, 2x3, 10x10, 0x77, 128x2, 200x200) -> 6 consecutive out_valid cycles with prod 1, 6, 100, 0, 256, 40000, in order.
- Stall: stream 3 ops, assert stall for 3 cycles while 2 are in flight -> prod/out_valid frozen during stall; results resume unchanged and in order afterwards; total latency extends by 3.
- Flush priority: 2 ops in flight, assert flush and stall together with in_valid=1 -> no out_valid for the next 5 cycles; busy=0 the cycle after.
- Reset mid-operation: issue 15x17, drop rst at cycle 2 asynchronously (between edges) -> out_valid, prod and busy go to 0 immediately; no result appears after release.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared constants, stage record and partial-product helper for the
// pipelined shift-and-add multiplier.
package mult_pkg;

    localparam int unsigned DEF_IN_W   = 8;
    localparam int unsigned DEF_STAGES = 4;
    localparam int unsigned DEF_BUS_W  = 16;

    localparam int unsigned SLICE_W = DEF_IN_W / DEF_STAGES;
    localparam int unsigned PROD_W  = 2 * DEF_IN_W;

    typedef struct packed {
        logic                valid;
        logic [DEF_IN_W-1:0] a;
        logic [DEF_IN_W-1:0] b;
        logic [PROD_W-1:0]   acc;
    } stage_t;

    // Sum of (a << j) over the set multiplier bits j of one slice; j is the
    // absolute bit index, so each stage adds correctly weighted terms.
    function automatic logic [PROD_W-1:0] slice_sum(
        input logic [DEF_IN_W-1:0] a,
        input logic [DEF_IN_W-1:0] b,
        input int unsigned         slice
    );
        logic [PROD_W-1:0] sum;
        sum = '0;
        for (int unsigned j = 0; j < SLICE_W; j++) begin
            if (b[slice*SLICE_W + j]) begin
                sum = sum + (PROD_W'(a) << (slice*SLICE_W + j));
            end
        end
        return sum;
    endfunction

endpackage

// File: rtl/mult_stage.sv
// One combinational multiplier stage: folds its slice of the multiplier
// into the running accumulator and forwards everything else untouched.
module mult_stage
    import mult_pkg::*;
#(
    parameter int unsigned SLICE = 0
) (
    input  stage_t prev_i,
    output stage_t next_o
);

    if (SLICE >= DEF_STAGES) begin : g_bad_slice
        $error("mult_stage: SLICE index out of range");
    end

    always_comb begin
        next_o     = prev_i;
        next_o.acc = prev_i.acc + slice_sum(prev_i.a, prev_i.b, SLICE);
    end

endmodule

// File: rtl/mult_pipe.sv
// Pipelined unsigned multiplier with stall and flush; result appears
// STAGES cycles after acceptance and issue rate is one per cycle.
module mult_pipe
    import mult_pkg::*;
#(
    parameter int unsigned IN_W   = DEF_IN_W,
    parameter int unsigned STAGES = DEF_STAGES,
    parameter int unsigned BUS_W  = DEF_BUS_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [BUS_W-1:0]  op_a,
    input  logic [BUS_W-1:0]  op_b,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    output logic [2*IN_W-1:0] prod,
    output logic              busy
);

    if (IN_W % STAGES != 0) begin : g_bad_split
        $error("mult_pipe: IN_W must be divisible by STAGES");
    end
    if (IN_W != DEF_IN_W || STAGES != DEF_STAGES) begin : g_bad_record
        $error("mult_pipe: stage record in mult_pkg is sized for the default IN_W/STAGES");
    end
    if (BUS_W < IN_W) begin : g_bad_bus
        $error("mult_pipe: BUS_W must be at least IN_W");
    end

    // Operand bus bits above IN_W are deliberately ignored.
    if (BUS_W > IN_W) begin : g_unused_hi
        logic unused_hi;
        always_comb unused_hi = ^{op_a[BUS_W-1:IN_W], op_b[BUS_W-1:IN_W]};
    end

    stage_t head;
    stage_t stg_in [STAGES];
    stage_t stg_d  [STAGES];
    stage_t stg_q  [STAGES];

    always_comb begin
        head       = '0;
        head.valid = in_valid;
        head.a     = op_a[IN_W-1:0];
        head.b     = op_b[IN_W-1:0];
    end

    // Stage 0 works on the live operands so the first slice is already
    // folded in when the first register captures.
    always_comb begin
        stg_in[0] = head;
        for (int unsigned k = 1; k < STAGES; k++) begin
            stg_in[k] = stg_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        mult_stage #(
            .SLICE(k)
        ) u_stage (
            .prev_i(stg_in[k]),
            .next_o(stg_d[k])
        );
    end

    // Flush outranks stall; data still loads on flush since only valids matter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                stg_q[k] <= '0;
            end
        end else if (flush) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                stg_q[k]       <= stg_d[k];
                stg_q[k].valid <= 1'b0;
            end
        end else if (!stall) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                stg_q[k] <= stg_d[k];
            end
        end
    end

    always_comb begin
        out_valid = stg_q[STAGES-1].valid;
        prod      = stg_q[STAGES-1].acc;
        busy      = 1'b0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            busy = busy | stg_q[k].valid;
        end
    end

endmodule

// File: tb/tb_mult_pipe.sv
// Directed scoreboard bench for mult_pipe: the driver queues hand-computed
// products, a negedge monitor pops one per newly presented result.
module tb_mult_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        stall;
    logic        flush;
    logic        out_valid;
    logic [15:0] prod;
    logic        busy;

    int          vectors;
    int          miscompares;
    logic [15:0] exp_q[$];
    logic        adv;

    mult_pipe #(
        .IN_W(8),
        .STAGES(4),
        .BUS_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .op_a(op_a),
        .op_b(op_b),
        .stall(stall),
        .flush(flush),
        .out_valid(out_valid),
        .prod(prod),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // An edge that was stalled leaves the same result on the output, so it
    // must not be counted as a new one.
    initial adv = 1'b1;
    always @(posedge clk) adv = !(stall && !flush);

    always @(negedge clk) begin
        if (rst && out_valid && adv) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_out: got prod 0x%0h with out_valid=1, expected no output at %0t",
                         prod, $time);
            end else begin
                chk("prod", {16'h0, prod}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        miscompares++;
        $display("FAIL timeout: bench did not complete, expected completion before 100000");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "timeout");
    end

    localparam int NSTR = 6;
    logic [15:0] str_a [NSTR] = '{16'd1, 16'd2, 16'd10, 16'd0,    16'd128, 16'd200};
    logic [15:0] str_b [NSTR] = '{16'd1, 16'd3, 16'd10, 16'h0077, 16'd2,   16'd200};
    logic [15:0] str_p [NSTR] = '{16'd1, 16'd6, 16'd100, 16'd0,   16'd256, 16'd40000};

    localparam int NST = 3;
    logic [15:0] st_a [NST] = '{16'd7,  16'd11,  16'd255};
    logic [15:0] st_b [NST] = '{16'd9,  16'd13,  16'd2};
    logic [15:0] st_p [NST] = '{16'd63, 16'd143, 16'd510};

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        in_valid    = 1'b0;
        op_a        = '0;
        op_b        = '0;
        stall       = 1'b0;
        flush       = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", {31'h0, out_valid}, 0);
        chk("rst_prod", {16'h0, prod}, 0);
        chk("rst_busy", {31'h0, busy}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Basic: 3 x 5, exact latency and busy window
        in_valid = 1'b1;
        op_a     = 16'h0003;
        op_b     = 16'h0005;
        exp_q.push_back(16'h000F);
        step();
        in_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("basic_busy", {31'h0, busy}, 1);
            chk("basic_out_valid", {31'h0, out_valid}, (i == 4) ? 1 : 0);
        end
        @(negedge clk);
        chk("basic_idle_busy", {31'h0, busy}, 0);
        step();

        // Max operands with junk in the ignored upper bytes
        in_valid = 1'b1;
        op_a     = 16'hABFF;
        op_b     = 16'h12FF;
        exp_q.push_back(16'hFE01);
        step();
        in_valid = 1'b0;
        repeat (6) step();

        // Back-to-back stream
        for (int i = 0; i < NSTR; i++) begin
            in_valid = 1'b1;
            op_a     = str_a[i];
            op_b     = str_b[i];
            exp_q.push_back(str_p[i]);
            step();
        end
        in_valid = 1'b0;
        repeat (8) step();
        chk("stream_drain", exp_q.size(), 0);

        // Stall with two operations still in flight behind the first result
        for (int i = 0; i < NST; i++) begin
            in_valid = 1'b1;
            op_a     = st_a[i];
            op_b     = st_b[i];
            exp_q.push_back(st_p[i]);
            step();
        end
        in_valid = 1'b0;
        step();
        stall = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall_out_valid", {31'h0, out_valid}, 1);
            chk("stall_prod", {16'h0, prod}, 63);
        end
        stall = 1'b0;
        repeat (6) step();
        chk("stall_drain", exp_q.size(), 0);

        // Flush together with stall and a fresh in_valid: nothing survives
        in_valid = 1'b1;
        op_a     = 16'd5;
        op_b     = 16'd5;
        step();
        op_a = 16'd6;
        op_b = 16'd6;
        step();
        flush = 1'b1;
        stall = 1'b1;
        op_a  = 16'd9;
        op_b  = 16'd9;
        step();
        flush    = 1'b0;
        stall    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_busy", {31'h0, busy}, 0);
        chk("flush_out_valid", {31'h0, out_valid}, 0);
        repeat (4) begin
            @(negedge clk);
            chk("flush_out_valid", {31'h0, out_valid}, 0);
        end
        step();

        // Asynchronous reset mid-operation
        in_valid = 1'b1;
        op_a     = 16'd15;
        op_b     = 16'd17;
        step();
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("pre_reset_busy", {31'h0, busy}, 1);
        #1 rst = 1'b0;
        #1;
        chk("areset_out_valid", {31'h0, out_valid}, 0);
        chk("areset_prod", {16'h0, prod}, 0);
        chk("areset_busy", {31'h0, busy}, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("post_reset_out_valid", {31'h0, out_valid}, 0);
        end

        chk("final_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
